// File: rtl/piano_pkg.sv
// Shared types and constants for the E-piano song sequencer.
// Holds the ROM word layout, the reserved key codes and the sequencer state encoding.
package piano_pkg;

   localparam logic [7:0]  KEY_REST  = 8'h00;
   localparam logic [11:0] ROM_END   = 12'h000;

   localparam int BEATS_MSB = 11;
   localparam int BEATS_LSB = 8;
   localparam int CODE_MSB  = 7;
   localparam int CODE_LSB  = 0;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      PLAY,
      GAP,
      DONE
   } seq_state_t;

endpackage

// File: rtl/beat_timer.sv
// Note-length timer: a BEAT_DIV prescaler feeding a 4-bit beat down-counter.
// expired is high in the final counted cycle of the loaded note.
module beat_timer #(
   parameter int BEAT_DIV = 12_500_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] beats,
   input  logic       hold,
   output logic       expired
);

   localparam int               PRE_W    = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BEAT_DIV - 1);

   logic [PRE_W-1:0] pre_q, pre_d;
   logic [3:0]       beats_q, beats_d;
   logic             tick;

   // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
   always_comb begin
      pre_d   = pre_q;
      beats_d = beats_q;
      tick    = !hold && (pre_q == PRE_LAST);
      expired = tick && (beats_q == 4'd1);

      if (load) begin
         pre_d   = '0;
         beats_d = beats;
      end else if (!hold) begin
         if (tick) begin
            pre_d = '0;
            if (beats_q != 4'd0) begin
               beats_d = beats_q - 4'd1;
            end
         end else begin
            pre_d = pre_q + PRE_W'(1);
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q   <= '0;
         beats_q <= 4'd0;
      end else begin
         pre_q   <= pre_d;
         beats_q <= beats_d;
      end
   end

endmodule

// File: rtl/piano_play_sequencer.sv
// Key-code source for the E-piano: forwards live keys or steps through the song ROM.
// A non-zero live key freezes an in-progress song; dropping mode aborts it.
module piano_play_sequencer
   import piano_pkg::*;
#(
   parameter int BEAT_DIV   = 12_500_000,
   parameter int GAP_CYCLES = 1_250_000,
   parameter int ADDR_W     = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        kb_code,
   input  logic              mode,
   input  logic              play_start,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [11:0]       rom_data,
   output logic [7:0]        key_code,
   output logic              busy,
   output logic              song_done
);

   localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   seq_state_t        state_q, state_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic [7:0]        key_code_q, key_code_d;
   logic [7:0]        note_q, note_d;
   logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
   logic              song_done_q, song_done_d;

   logic       override;
   logic       last_addr;
   logic       timer_load;
   logic       timer_hold;
   logic       beat_expired;
   logic [3:0] rom_beats;
   logic [7:0] rom_code;

   assign rom_beats = rom_data[BEATS_MSB:BEATS_LSB];
   assign rom_code  = rom_data[CODE_MSB:CODE_LSB];
   assign last_addr = &rom_addr_q;
   assign override  = (state_q != IDLE) && (kb_code != KEY_REST);
   assign timer_hold = override || (state_q != PLAY);

   beat_timer #(
      .BEAT_DIV (BEAT_DIV)
   ) u_beat_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (timer_load),
      .beats   (rom_beats),
      .hold    (timer_hold),
      .expired (beat_expired)
   );

   always_comb begin
      state_d     = state_q;
      rom_addr_d  = rom_addr_q;
      key_code_d  = key_code_q;
      note_d      = note_q;
      gap_cnt_d   = gap_cnt_q;
      song_done_d = 1'b0;
      timer_load  = 1'b0;

      if ((state_q != IDLE) && !mode) begin
         state_d    = IDLE;
         rom_addr_d = '0;
         gap_cnt_d  = '0;
         key_code_d = kb_code;
      end else if (override) begin
         // Live key wins; everything else holds until the key is released.
         key_code_d = kb_code;
      end else begin
         unique case (state_q)
            IDLE: begin
               key_code_d = kb_code;
               if (mode && play_start) begin
                  state_d    = FETCH;
                  rom_addr_d = '0;
               end
            end
            FETCH: begin
               key_code_d = KEY_REST;
               state_d    = LOAD;
            end
            LOAD: begin
               key_code_d = KEY_REST;
               if (rom_data == ROM_END) begin
                  state_d = DONE;
               end else if (rom_beats == 4'd0) begin
                  if (last_addr) begin
                     state_d = DONE;
                  end else begin
                     rom_addr_d = rom_addr_q + ADDR_W'(1);
                     state_d    = FETCH;
                  end
               end else begin
                  key_code_d = rom_code;
                  note_d     = rom_code;
                  timer_load = 1'b1;
                  state_d    = PLAY;
               end
            end
            PLAY: begin
               if (beat_expired) begin
                  key_code_d = KEY_REST;
                  gap_cnt_d  = '0;
                  state_d    = GAP;
               end else begin
                  key_code_d = note_q;
               end
            end
            GAP: begin
               key_code_d = KEY_REST;
               if (gap_cnt_q == GAP_LAST) begin
                  gap_cnt_d = '0;
                  if (last_addr) begin
                     state_d = DONE;
                  end else begin
                     rom_addr_d = rom_addr_q + ADDR_W'(1);
                     state_d    = FETCH;
                  end
               end else begin
                  gap_cnt_d = gap_cnt_q + GAP_W'(1);
               end
            end
            DONE: begin
               key_code_d  = KEY_REST;
               song_done_d = 1'b1;
               state_d     = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rom_addr_q  <= '0;
         key_code_q  <= KEY_REST;
         note_q      <= KEY_REST;
         gap_cnt_q   <= '0;
         song_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rom_addr_q  <= rom_addr_d;
         key_code_q  <= key_code_d;
         note_q      <= note_d;
         gap_cnt_q   <= gap_cnt_d;
         song_done_q <= song_done_d;
      end
   end

   assign rom_addr  = rom_addr_q;
   assign key_code  = key_code_q;
   assign busy      = (state_q != IDLE);
   assign song_done = song_done_q;

endmodule
